// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: UART receiver with configurable data width, parity and stop bits.
// The receiver uses a two-flop synchroniser and a 3-sample majority vote.
// It rejects false starts, flags parity, framing and overrun errors, and
// delivers each word through a valid/ready handshake.
module uart_rx_cfg #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 serial_in,
    input  logic                 i_ready,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy,
    output logic [2:0]           state
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_START  = 3'b001,
        S_DATA   = 3'b010,
        S_PARITY = 3'b011,
        S_STOP   = 3'b100,
        S_WAIT   = 3'b101
    } state_t;

    state_t               state_q, state_n;
    logic                 sync1_q, sync2_q;
    logic [2:0]           win_q;
    logic                 voted_c;
    logic [CNT_W-1:0]     cnt_q, cnt_n;
    logic [IDX_W-1:0]     idx_q, idx_n;
    logic                 stop_q, stop_n;
    logic [DATA_BITS-1:0] shreg_q, shreg_n;
    logic                 perr_q, perr_n;
    logic                 ferr_q, ferr_n;
    logic                 done_c;

    // Two-flop synchroniser followed by the 3-sample vote window; idle-high on reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            win_q   <= 3'b111;
        end else begin
            sync1_q <= serial_in;
            sync2_q <= sync1_q;
            win_q   <= {win_q[1:0], sync2_q};
        end
    end

    assign voted_c = (win_q[0] & win_q[1]) | (win_q[0] & win_q[2]) | (win_q[1] & win_q[2]);

    // Frame state register and per-frame working registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            shreg_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            idx_q   <= idx_n;
            stop_q  <= stop_n;
            shreg_q <= shreg_n;
            perr_q  <= perr_n;
            ferr_q  <= ferr_n;
            o_busy  <= (state_n != S_IDLE);
        end
    end

    assign state = state_q;

    // Next-state logic: count to mid-start, then decide at every bit centre
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        idx_n   = idx_q;
        stop_n  = stop_q;
        shreg_n = shreg_q;
        perr_n  = perr_q;
        ferr_n  = ferr_q;
        done_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_n = '0;
                if (!sync2_q) begin
                    state_n = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_CNT) begin
                    if (voted_c) begin
                        state_n = S_IDLE;
                    end else begin
                        cnt_n   = '0;
                        idx_n   = '0;
                        perr_n  = 1'b0;
                        ferr_n  = 1'b0;
                        state_n = S_DATA;
                    end
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_n          = '0;
                    shreg_n[idx_q] = voted_c;
                    if (idx_q == LAST_IDX) begin
                        stop_n  = 1'b0;
                        state_n = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_n = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            S_PARITY: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_n   = '0;
                    perr_n  = (PARITY == 1) ? ~(^shreg_q ^ voted_c) : (^shreg_q ^ voted_c);
                    stop_n  = 1'b0;
                    state_n = S_STOP;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_n  = '0;
                    ferr_n = ferr_q | ~voted_c;
                    if (stop_q == LAST_STOP) begin
                        done_c  = 1'b1;
                        state_n = ferr_n ? S_WAIT : S_IDLE;
                    end else begin
                        stop_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (sync2_q) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Output holding register: load on completion unless a word is still unconsumed
    always_ff @(posedge clock) begin
        if (!reset) begin
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            if (done_c) begin
                if (!o_valid || i_ready) begin
                    o_data       <= shreg_q;
                    o_parity_err <= perr_q;
                    o_frame_err  <= ferr_n;
                    o_valid      <= 1'b1;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: two receiver configurations (8N1 and 7E2) against a frame-level model.
module tb_uart_rx_cfg;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic [1:0] ser, rdy, vld, pe, fe, ov, bz;
    logic [7:0] d0;
    logic [6:0] d1;
    logic [2:0] st0, st1;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_rx0 (
        .clock(clock), .reset(reset), .serial_in(ser[0]), .i_ready(rdy[0]),
        .o_data(d0), .o_valid(vld[0]), .o_parity_err(pe[0]), .o_frame_err(fe[0]),
        .o_overrun(ov[0]), .o_busy(bz[0]), .state(st0)
    );

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_rx1 (
        .clock(clock), .reset(reset), .serial_in(ser[1]), .i_ready(rdy[1]),
        .o_data(d1), .o_valid(vld[1]), .o_parity_err(pe[1]), .o_frame_err(fe[1]),
        .o_overrun(ov[1]), .o_busy(bz[1]), .state(st1)
    );

    int cfg_db  [2] = '{8, 7};
    int cfg_par [2] = '{0, 2};
    int cfg_sb  [2] = '{1, 2};

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model state: expected held word per unit plus a FIFO of scheduled completions
    int          edge_n = 0;
    bit   [1:0]  mv, mpe, mfe, mov;
    logic [8:0]  md [2];
    int          pend_edge [2][16];
    logic [8:0]  pend_d    [2][16];
    bit          pend_pe   [2][16];
    bit          pend_fe   [2][16];
    int          wp [2] = '{0, 0};
    int          rp [2] = '{0, 0};

    bit [1:0] rnd_rdy = 2'b00;
    int       pulse_edge [2] = '{-10, -10};
    int       ov_cnt [2];
    bit [1:0] busy_seen;

    // Frame-level reference: each frame completes at its computed edge, then the
    // handshake rules decide between load, overrun and consume
    always @(posedge clock) begin
        edge_n = edge_n + 1;
        for (int u = 0; u < 2; u++) begin
            mov[u] = 1'b0;
            if (!reset) begin
                mv[u]  = 1'b0;
                md[u]  = '0;
                mpe[u] = 1'b0;
                mfe[u] = 1'b0;
                rp[u]  = wp[u];
            end else if (rp[u] != wp[u] && pend_edge[u][rp[u] % 16] == edge_n) begin
                if (!mv[u] || rdy[u]) begin
                    mv[u]  = 1'b1;
                    md[u]  = pend_d[u][rp[u] % 16];
                    mpe[u] = pend_pe[u][rp[u] % 16];
                    mfe[u] = pend_fe[u][rp[u] % 16];
                end else begin
                    mov[u] = 1'b1;
                end
                rp[u] = rp[u] + 1;
            end else if (mv[u] && rdy[u]) begin
                mv[u] = 1'b0;
            end
        end
    end

    function automatic logic [8:0] dat(input int u);
        return (u == 0) ? {1'b0, d0} : {2'b00, d1};
    endfunction

    function automatic logic [2:0] st(input int u);
        return (u == 0) ? st0 : st1;
    endfunction

    task automatic chk(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s unit%0d: got 0x%0h expected 0x%0h at t=%0t", nm, u, act, exp, $time);
        end
    endtask

    // One clock: compare every output against the model at the falling edge, then drive
    task automatic tick();
        @(negedge clock);
        if (chk_en) begin
            for (int u = 0; u < 2; u++) begin
                chk("o_valid", u, 32'(vld[u]), 32'(mv[u]));
                chk("o_data", u, 32'(dat(u)), 32'(md[u]));
                chk("o_parity_err", u, 32'(pe[u]), 32'(mpe[u]));
                chk("o_frame_err", u, 32'(fe[u]), 32'(mfe[u]));
                chk("o_overrun", u, 32'(ov[u]), 32'(mov[u]));
                if (ov[u]) ov_cnt[u]++;
                if (bz[u]) busy_seen[u] = 1'b1;
            end
        end
        @(posedge clock);
        #1;
        for (int u = 0; u < 2; u++) begin
            if (rnd_rdy[u]) rdy[u] = ($urandom_range(0, 2) == 0);
            else if (edge_n == pulse_edge[u]) rdy[u] = 1'b1;
            else if (edge_n == pulse_edge[u] + 1) rdy[u] = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        ser = 2'b11;
        repeat (n) tick();
    endtask

    task automatic consume(input int u);
        rdy[u] = 1'b1;
        tick();
        rdy[u] = 1'b0;
    endtask

    // Serialise one frame; pforce<0 sends the correct parity bit, else forces it
    task automatic send_frame(input int u, input logic [8:0] data, input int pforce,
                              input bit s0, input bit s1, input int glitch_b,
                              input bit pulse, input int abort_b);
        bit   bits [14];
        int   nb, ones, e, k;
        bit   pbit, perr, ferr;
        logic [8:0] dm;
        dm   = data & 9'((1 << cfg_db[u]) - 1);
        ones = 0;
        k    = 0;
        bits[k++] = 1'b0;
        for (int i = 0; i < cfg_db[u]; i++) begin
            bits[k++] = dm[i];
            ones += int'(dm[i]);
        end
        perr = 1'b0;
        if (cfg_par[u] != 0) begin
            if (pforce < 0) pbit = (cfg_par[u] == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
            else            pbit = (pforce != 0);
            bits[k++] = pbit;
            perr = (cfg_par[u] == 1) ? (((ones + int'(pbit)) % 2) == 0)
                                     : (((ones + int'(pbit)) % 2) == 1);
        end
        bits[k++] = s0;
        if (cfg_sb[u] == 2) bits[k++] = s1;
        ferr = !s0 || (cfg_sb[u] == 2 && !s1);
        nb = k - 1;
        e  = edge_n;
        // Sync (2) + idle detect (1) + half-bit count + nb full bit periods
        pend_edge[u][wp[u] % 16] = e + 4 + HALF + CPB * nb;
        pend_d[u][wp[u] % 16]    = dm;
        pend_pe[u][wp[u] % 16]   = perr;
        pend_fe[u][wp[u] % 16]   = ferr;
        wp[u] = wp[u] + 1;
        if (pulse) pulse_edge[u] = e + 3 + HALF + CPB * nb;
        for (int b = 0; b <= nb; b++) begin
            for (int c = 0; c < CPB; c++) begin
                if (b == abort_b && c == 0) begin
                    chk("mid_state", u, 32'(st(u)), 32'h2);
                    chk("mid_busy", u, 32'(bz[u]), 32'h1);
                    ser[u] = 1'b1;
                    reset  = 1'b0;
                    repeat (3) tick();
                    chk("rst_valid", u, 32'(vld[u]), 32'h0);
                    chk("rst_data", u, 32'(dat(u)), 32'h0);
                    chk("rst_state", u, 32'(st(u)), 32'h0);
                    chk("rst_busy", u, 32'(bz[u]), 32'h0);
                    reset = 1'b1;
                    return;
                end
                ser[u] = (b == glitch_b && c == HALF) ? ~bits[b] : bits[b];
                tick();
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        logic [8:0] dr;
        bit s0r, s1r;
        int pf;
        reset = 1'b0;
        ser   = 2'b11;
        rdy   = 2'b00;
        repeat (3) tick();
        chk("reset_valid", 0, 32'(vld[0]), 32'h0);
        chk("reset_state", 1, 32'(st1), 32'h0);
        chk("reset_busy", 0, 32'(bz[0]), 32'h0);
        reset  = 1'b1;
        chk_en = 1'b1;
        idle(5);

        // 8N1 basic word held until accepted
        send_frame(0, 9'h0A5, -1, 1'b1, 1'b1, -1, 1'b0, -1);
        chk("a5_data", 0, 32'(d0), 32'hA5);
        chk("a5_valid", 0, 32'(vld[0]), 32'h1);
        chk("a5_flags", 0, 32'({pe[0], fe[0]}), 32'h0);
        idle(100);
        chk("a5_held", 0, 32'({vld[0], d0}), 32'h1A5);
        consume(0);
        chk("a5_consumed", 0, 32'(vld[0]), 32'h0);

        // False start: short low pulse
        busy_seen = 2'b00;
        e0 = edge_n;
        ser[0] = 1'b0;
        repeat (3) tick();
        ser[0] = 1'b1;
        while (edge_n < e0 + 8) tick();
        chk("fs_start", 0, 32'(st0), 32'h1);
        while (edge_n < e0 + 12) tick();
        chk("fs_idle", 0, 32'(st0), 32'h0);
        chk("fs_busy_pulse", 0, 32'(busy_seen[0]), 32'h1);
        idle(10);

        // Single-cycle glitch at the centre of data bit 2
        send_frame(0, 9'h03C, -1, 1'b1, 1'b1, 3, 1'b0, -1);
        chk("glitch_data", 0, 32'(d0), 32'h3C);
        consume(0);
        idle(5);

        // 7E2: wrong then right parity bit
        send_frame(1, 9'h037, 0, 1'b1, 1'b1, -1, 1'b0, -1);
        chk("par_bad_data", 1, 32'(d1), 32'h37);
        chk("par_bad_err", 1, 32'(pe[1]), 32'h1);
        consume(1);
        send_frame(1, 9'h037, 1, 1'b1, 1'b1, -1, 1'b0, -1);
        chk("par_ok_err", 1, 32'(pe[1]), 32'h0);
        consume(1);
        idle(5);

        // Second stop bit low, then a held break
        send_frame(1, 9'h02A, -1, 1'b1, 1'b0, -1, 1'b0, -1);
        ser[1] = 1'b0;
        repeat (40) tick();
        chk("brk_ferr", 1, 32'(fe[1]), 32'h1);
        chk("brk_wait", 1, 32'(st1), 32'h5);
        idle(6);
        chk("brk_idle", 1, 32'(st1), 32'h0);
        consume(1);
        send_frame(1, 9'h055, -1, 1'b1, 1'b1, -1, 1'b0, -1);
        chk("after_brk", 1, 32'({pe[1], fe[1], d1}), 32'h055);
        consume(1);
        idle(5);

        // Back-to-back overrun, then a same-cycle handshake that avoids it
        ov_cnt[0] = 0;
        send_frame(0, 9'h011, -1, 1'b1, 1'b1, -1, 1'b0, -1);
        send_frame(0, 9'h022, -1, 1'b1, 1'b1, -1, 1'b0, -1);
        chk("ovr_data", 0, 32'(d0), 32'h11);
        chk("ovr_pulses", 0, 32'(ov_cnt[0]), 32'h1);
        consume(0);
        chk("ovr_consumed", 0, 32'(vld[0]), 32'h0);
        ov_cnt[0] = 0;
        send_frame(0, 9'h011, -1, 1'b1, 1'b1, -1, 1'b0, -1);
        send_frame(0, 9'h022, -1, 1'b1, 1'b1, -1, 1'b1, -1);
        chk("hs_data", 0, 32'({vld[0], d0}), 32'h122);
        chk("hs_no_ovr", 0, 32'(ov_cnt[0]), 32'h0);
        consume(0);
        idle(5);

        // Reset during data bit 4, then a clean word
        send_frame(0, 9'h0C3, -1, 1'b1, 1'b1, -1, 1'b0, 5);
        idle(5);
        send_frame(0, 9'h0F0, -1, 1'b1, 1'b1, -1, 1'b0, -1);
        chk("post_rst", 0, 32'(d0), 32'hF0);
        consume(0);
        idle(5);

        // Randomised frames, errors and consumer stalls on both units
        for (int u = 0; u < 2; u++) begin
            rnd_rdy[u] = 1'b1;
            for (int n = 0; n < 40; n++) begin
                dr  = 9'($urandom);
                pf  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 1)) : -1;
                s0r = ($urandom_range(0, 5) != 0);
                s1r = ($urandom_range(0, 5) != 0);
                send_frame(u, dr, pf, s0r, s1r, -1, 1'b0, -1);
                if (!s0r || (cfg_sb[u] == 2 && !s1r)) idle($urandom_range(6, 20));
                else                                  idle($urandom_range(0, 20));
            end
            rnd_rdy[u] = 1'b0;
            rdy[u]     = 1'b0;
            idle(10);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 receiver. Adds configurable data width, parity and stop-bit count. Uses a 2-flop input synchroniser, 3-sample majority voting, false-start rejection, parity, framing and overrun flags, and a valid/ready output handshake. Sits between the board RX pin and the command/packet parser.

Parameters:
CLKS_PER_BIT, 868, clock cycles per bit period (100 MHz / 115200); minimum 8
DATA_BITS, 8, data bits per frame, 5..9, LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
serial_in  in  1  asynchronous RX line, idle high
i_ready  in  1  consumer accepts o_data when high with o_valid
o_data  out  DATA_BITS  received word
o_valid  out  1  o_data and error flags are valid, held until accepted
o_parity_err  out  1  parity mismatch on the held word (0 when PARITY = 0)
o_frame_err  out  1  a stop bit was sampled low on the held word
o_overrun  out  1  one-cycle pulse: a completed frame was dropped
o_busy  out  1  high in every state except IDLE
state  out  3  FSM state: IDLE=000, START=001, DATA=010, PARITY=011, STOP=100, WAIT_HIGH=101

Behaviour:
- Reset (reset = 0 at a clock edge): synchroniser and sample window set to all 1s, so no false start. State IDLE. Counters 0. All outputs 0.
- Input path: serial_in passes through 2 flops and then a 3-bit shift window. The voted bit is the majority of the 3 window bits.
- IDLE: when the synchronised line is 0, go to START with counter = 0.
- START: counter increments each cycle. At counter == CLKS_PER_BIT/2, evaluate the voted bit:
  - If 1: false start; return to IDLE, no output.
  - If 0: counter = 0, bit index = 0, go to DATA.
- Decision point for DATA, PARITY and STOP: the cycle where counter == CLKS_PER_BIT-1. Take the voted bit, then set counter = 0. This samples at each bit centre.
- DATA: store the voted bit at position bit_index (LSB first). After bit DATA_BITS-1, go to PARITY if PARITY != 0, otherwise go to STOP.
- PARITY: the error check is:
  - odd: error if popcount(data) + parity bit is even.
  - even: error if popcount(data) + parity bit is odd.
  - Then go to STOP.
- STOP: sample STOP_BITS stop bits. The frame error flag is set if any stop bit is voted 0. On the last stop decision the frame is complete:
  - Frame error: go to WAIT_HIGH.
  - No frame error: go to IDLE. Returning at mid-stop allows back-to-back frames.
- WAIT_HIGH: stay until the synchronised line is 1, then go to IDLE. This covers break recovery.
- Frame completion, latched on the clock after the last stop decision:
  - If o_valid = 0, or i_ready = 1 in that cycle: load o_data and the error flags, set o_valid = 1. A same-cycle handshake counts as consumed, so there is no overrun.
  - Otherwise the new frame is dropped, the held word and flags are unchanged, and o_overrun is high for 1 cycle.
- Handshake: o_valid && i_ready at a clock edge clears o_valid, unless a new frame loads in that same cycle. o_data and the flags hold their value after being consumed.
- A framing-error word is still delivered, with o_frame_err = 1.
- Latency: o_valid rises 1 cycle after the decision point of the last stop bit.
- A reset asserted in any state aborts the frame. No partial word is ever delivered.

Test Plan:
- Default 8N1, CLKS_PER_BIT=16, send 0xA5, i_ready=0 -> o_valid=1, o_data=0xA5, both error flags 0, held for 100 cycles; pulse i_ready -> o_valid=0 on the next cycle.
- False start: serial_in low for 3 cycles, then high -> state returns to IDLE after 8 cycles; o_valid stays 0; o_busy pulses.
- Glitch immunity: send 0x3C with a single-cycle inverted glitch at the centre of bit 2 -> o_data=0x3C.
- PARITY=2, DATA_BITS=7: send 0x37 with parity bit 0 (correct bit is 1) -> o_data=0x37, o_parity_err=1; resend with parity bit 1 -> o_parity_err=0.
- STOP_BITS=2: second stop bit low and the line held low for 40 cycles -> o_frame_err=1, state=WAIT_HIGH until the line goes high, then IDLE; the next frame 0x55 is received cleanly.
- Overrun: with i_ready=0, send 0x11 then 0x22 back to back -> o_data stays 0x11, o_overrun is high for exactly 1 cycle; assert i_ready -> 0x11 consumed. Repeat with i_ready=1 pulsed in the completion cycle -> 0x22 loaded, no overrun.
- Reset mid-frame: set reset=0 at DATA bit 4 -> all outputs 0, state IDLE; after release, 0xF0 is received correctly.
